// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the digit value source and the 7-segment scan controller.
// The source drives the digit values and scan enable; the controller returns decoder/pin drives.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    lzb_en;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output en, digits_in, lzb_en,
    input  bcd_out, digit_en, frame_done
  );

  modport slave (
    input  en, digits_in, lzb_en,
    output bcd_out, digit_en, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS digits through one shared BCD decoder,
// with an all-off gap between digits, per-frame input snapshot and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 16
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [IW-1:0]           idx_r, idx_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic [4*NUM_DIGITS-1:0] snap_r, snap_s;
  logic                    snap_lzb_r, snap_lzb_s;
  logic                    advance_s;
  logic                    wrap_s;
  logic [NUM_DIGITS-1:0]   mask_s;
  logic [3:0]              bcd_r, bcd_s;
  logic [NUM_DIGITS-1:0]   digit_en_r, digit_en_s;
  logic                    frame_done_r;

  // Digit i>0 is blanked when it and every more significant nibble are zero.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic                    lz
  );
    logic zero_run;
    zero_run = 1'b1;
    lzb_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run & (d[4*i +: 4] == 4'h0);
      lzb_mask[i] = lz & zero_run;
    end
  endfunction

  // Next-state logic: slot counters, digit index and snapshot reload at frame wrap.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    snap_s     = snap_r;
    snap_lzb_s = snap_lzb_r;
    advance_s  = 1'b0;
    wrap_s     = 1'b0;
    if (!bus.en) begin
      state_s = ST_IDLE;
      idx_s   = '0;
      cnt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s    = ST_SHOW;
          idx_s      = '0;
          cnt_s      = '0;
          snap_s     = bus.digits_in;
          snap_lzb_s = bus.lzb_en;
        end
        ST_SHOW: begin
          if (cnt_r == DIV_LAST) begin
            cnt_s = '0;
            if (BLANK_CYC > 0) begin
              state_s = ST_BLANK;
            end else begin
              advance_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            cnt_s     = '0;
            advance_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          idx_s   = '0;
          cnt_s   = '0;
        end
      endcase
      // Leaving the last digit wraps the frame and takes a fresh snapshot.
      if (advance_s) begin
        state_s = ST_SHOW;
        if (idx_r != IDX_LAST) begin
          idx_s = idx_r + 1'b1;
        end else begin
          idx_s      = '0;
          snap_s     = bus.digits_in;
          snap_lzb_s = bus.lzb_en;
          wrap_s     = 1'b1;
        end
      end else begin
        wrap_s = 1'b0;
      end
    end
  end

  // Output decode from next state so the pins come straight from flops.
  always_comb begin
    mask_s     = lzb_mask(snap_s, snap_lzb_s);
    bcd_s      = 4'hF;
    digit_en_s = '0;
    if (state_s == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_s == IW'(i)) begin
          digit_en_s[i] = 1'b1;
          bcd_s         = mask_s[i] ? 4'hF : snap_s[4*i +: 4];
        end else begin
          digit_en_s[i] = 1'b0;
        end
      end
    end else begin
      bcd_s      = 4'hF;
      digit_en_s = '0;
    end
  end

  // State, snapshot and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      snap_r       <= '0;
      snap_lzb_r   <= 1'b0;
      bcd_r        <= 4'hF;
      digit_en_r   <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      snap_r       <= snap_s;
      snap_lzb_r   <= snap_lzb_s;
      bcd_r        <= bcd_s;
      digit_en_r   <= digit_en_s;
      frame_done_r <= wrap_s;
    end
  end

  assign bus.bcd_out    = bcd_r;
  assign bus.digit_en   = digit_en_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a 4-digit instance (DIV=4, BLANK_CYC=2)
// and a 1-digit instance (DIV=2, BLANK_CYC=0).
module tb_seg7_scan_ctrl;

  typedef struct packed {
    logic [3:0] den;
    logic [3:0] bcd;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [3:0] prev_den;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus1 ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(1)) bus2 ();

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYC(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(1), .DIV(2), .BLANK_CYC(0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle: one-hot digit enables, blank code when all off, and a gap between digits.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(bus1.digit_en) && $onehot0(bus2.digit_en) &&
            ((bus1.digit_en != 4'b0000) || (bus1.bcd_out == 4'hF)) &&
            !((prev_den != 4'b0000) && (bus1.digit_en != 4'b0000) && (bus1.digit_en != prev_den)))
    else begin
      errors++;
      $display("FAIL onehot_gap t=%0t: digit_en=%b prev=%b bcd=%h (need one-hot, gap, F when off)",
               $time, bus1.digit_en, prev_den, bus1.bcd_out);
    end
    prev_den = bus1.digit_en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Expected cycles for one 4-digit frame, computed from the digit value and blanking rule.
  task automatic push_frame(input logic [15:0] d, input logic lz, input logic fd_first);
    exp_t e;
    logic [15:0] upper;
    logic        blanked;
    for (int dig = 0; dig < 4; dig++) begin
      upper   = d >> (4 * dig);
      blanked = lz && (dig > 0) && (upper == 16'h0000);
      for (int c = 0; c < 4; c++) begin
        e.den = 4'b0001 << dig;
        e.bcd = blanked ? 4'hF : upper[3:0];
        e.fd  = (dig == 0 && c == 0) ? fd_first : 1'b0;
        sb.push_back(e);
      end
      for (int c = 0; c < 2; c++) begin
        e = '{den: 4'b0000, bcd: 4'hF, fd: 1'b0};
        sb.push_back(e);
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    @(negedge clk);
    if (sb.size() == 0) begin
      e = '{den: 4'bxxxx, bcd: 4'hx, fd: 1'bx};
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic start_scan(input logic [15:0] d, input logic lz);
    bus1.digits_in = d;
    bus1.lzb_en    = lz;
    bus1.en        = 1'b1;
  endtask

  task automatic stop_scan();
    bus1.en = 1'b0;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.en = 1'b0; bus1.digits_in = 16'h0000; bus1.lzb_en = 1'b0;
    bus2.en = 1'b0; bus2.digits_in = 4'h0;     bus2.lzb_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {4'b0000, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset: got den=%b bcd=%h fd=%b, expected 0000/F/0",
               bus1.digit_en, bus1.bcd_out, bus1.frame_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {4'b0000, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_reset: got den=%b bcd=%h fd=%b, expected 0000/F/0",
               bus1.digit_en, bus1.bcd_out, bus1.frame_done);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    start_scan(16'h1234, 1'b0);
    push_frame(16'h1234, 1'b0, 1'b0);
    push_frame(16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL scan cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
    end
    stop_scan();
  endtask

  task automatic test_lzb();
    exp_t e;
    start_scan(16'h0050, 1'b1);
    push_frame(16'h0050, 1'b1, 1'b0);
    push_frame(16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 48; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL lzb cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
      if (i == 0) bus1.digits_in = 16'h0000;
    end
    stop_scan();
  endtask

  task automatic test_snapshot();
    exp_t e;
    start_scan(16'h1234, 1'b0);
    push_frame(16'h1234, 1'b0, 1'b0);
    push_frame(16'h9876, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL snapshot cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
      if (i == 9) bus1.digits_in = 16'h9876;
    end
    stop_scan();
  endtask

  task automatic test_en_drop();
    exp_t e;
    start_scan(16'h1234, 1'b0);
    push_frame(16'h1234, 1'b0, 1'b0);
    // Cycle 16 is the first BLANK cycle after digit 2.
    for (int i = 0; i < 17; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL en_drop_pre cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
    end
    sb.delete();
    bus1.en = 1'b0;
    bus1.digits_in = 16'h5678;
    @(negedge clk);
    checks++;
    if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {4'b0000, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL en_drop_idle: got den=%b bcd=%h fd=%b, expected 0000/F/0",
               bus1.digit_en, bus1.bcd_out, bus1.frame_done);
    end
    bus1.en = 1'b1;
    push_frame(16'h5678, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL en_restart cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
    end
    stop_scan();
  endtask

  task automatic test_async_reset();
    exp_t e;
    start_scan(16'h4321, 1'b0);
    push_frame(16'h4321, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL arst_pre cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
    end
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {4'b0000, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL arst_async: got den=%b bcd=%h fd=%b, expected 0000/F/0",
               bus1.digit_en, bus1.bcd_out, bus1.frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h4321, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pop_exp(e);
      checks++;
      if ({bus1.digit_en, bus1.bcd_out, bus1.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL arst_restart cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus1.digit_en, bus1.bcd_out, bus1.frame_done, e.den, e.bcd, e.fd);
      end
    end
    stop_scan();
  endtask

  task automatic test_single_digit();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      e.den = 4'b0001;
      e.bcd = (i >= 4) ? 4'hA : 4'h7;
      e.fd  = (i >= 2) && ((i % 2) == 0);
      sb.push_back(e);
    end
    bus2.digits_in = 4'h7;
    bus2.lzb_en    = 1'b1;
    bus2.en        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pop_exp(e);
      checks++;
      if ({3'b000, bus2.digit_en, bus2.bcd_out, bus2.frame_done} !== {e.den, e.bcd, e.fd}) begin
        errors++;
        $display("FAIL single cyc %0d: got den=%b bcd=%h fd=%b, expected den=%b bcd=%h fd=%b",
                 i, bus2.digit_en, bus2.bcd_out, bus2.frame_done, e.den[0], e.bcd, e.fd);
      end
      if (i == 2) bus2.digits_in = 4'hA;
    end
    bus2.en = 1'b0;
    @(negedge clk);
    sb.delete();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    prev_den = 4'b0000;
    test_reset();
    test_scan();
    test_lzb();
    test_snapshot();
    test_en_drop();
    test_async_reset();
    test_single_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
